// File: rtl/num_ascii_serializer.sv
// Reads signed 32-bit integers from a RAM and streams them as ASCII decimal text,
// space-separated and newline-terminated, over a valid/ready byte interface.
module num_ascii_serializer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready
);

   typedef enum logic [2:0] {
      StIdle, StRdReq, StRdWait, StConv, StEmitSign, StEmitDig, StEmitSep, StFinish
   } state_e;

   localparam logic [ADDR_WIDTH:0] MaxCount = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   idx_q, idx_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  neg_q, neg_d;
   logic [DATA_WIDTH-1:0] bin_q, bin_d;
   logic [9:0][3:0]       bcd_q, bcd_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [3:0]            dig_q, dig_d;

   logic [8:0][3:0]       adj;
   logic [9:0][3:0]       bcd_step;
   logic [3:0]            msd_step;
   logic [ADDR_WIDTH:0]   idx_nxt;
   logic                  last_num;

   // One shift-add-3 step; the top digit never exceeds 4 so it needs no adjust.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
      end
      bcd_step = {bcd_q[9][2:0], adj, bin_q[DATA_WIDTH-1]};
      msd_step = '0;
      for (int i = 1; i < 10; i++) begin
         if (bcd_step[i] != 4'd0) msd_step = 4'(i);
      end
   end

   assign idx_nxt  = idx_q + 1'b1;
   assign last_num = (idx_nxt >= count_q);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      count_d   = count_q;
      rd_addr_d = rd_addr_q;
      neg_d     = neg_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      dig_d     = dig_q;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               count_d = (count > MaxCount) ? MaxCount : count;
               idx_d   = '0;
               if (count == '0) begin
                  state_d = StFinish;
               end else begin
                  rd_addr_d = '0;
                  state_d   = StRdReq;
               end
            end
         end
         StRdReq: state_d = StRdWait;
         StRdWait: begin
            neg_d   = rd_data[DATA_WIDTH-1];
            bin_d   = rd_data[DATA_WIDTH-1] ? -rd_data : rd_data;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = StConv;
         end
         StConv: begin
            bin_d = {bin_q[DATA_WIDTH-2:0], 1'b0};
            bcd_d = bcd_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               dig_d   = msd_step;
               state_d = neg_q ? StEmitSign : StEmitDig;
            end
         end
         StEmitSign: begin
            tx_valid = 1'b1;
            tx_data  = 8'h2D;
            if (tx_ready) state_d = StEmitDig;
         end
         StEmitDig: begin
            tx_valid = 1'b1;
            tx_data  = 8'h30 + {4'h0, bcd_q[dig_q]};
            if (tx_ready) begin
               if (dig_q == 4'd0) state_d = StEmitSep;
               else               dig_d   = dig_q - 4'd1;
            end
         end
         StEmitSep: begin
            tx_valid = 1'b1;
            tx_data  = last_num ? 8'h0A : 8'h20;
            if (tx_ready) begin
               if (last_num) begin
                  state_d = StFinish;
               end else begin
                  idx_d     = idx_nxt;
                  rd_addr_d = idx_nxt[ADDR_WIDTH-1:0];
                  state_d   = StRdReq;
               end
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         count_q   <= '0;
         rd_addr_q <= '0;
         neg_q     <= 1'b0;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         dig_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         count_q   <= count_d;
         rd_addr_q <= rd_addr_d;
         neg_q     <= neg_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         dig_q     <= dig_d;
      end
   end

   assign busy    = (state_q != StIdle) && (state_q != StFinish);
   assign done    = (state_q == StFinish);
   assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_num_ascii_serializer.sv
// Scoreboard bench: expected ASCII bytes are queued from a decimal-format model when a job
// is launched and compared against bytes the monitor captures on accepted handshakes.
module tb_num_ascii_serializer;
   localparam int DW = 32;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [AW:0]   count;
   logic          busy, done;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [7:0]    tx_data;
   logic          tx_valid, tx_ready;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            ready_mode = 0;
   logic          rnd_bit = 1'b0;
   int            cyc = 0;

   logic [7:0]    got_q[$];
   int            got_cyc[$];
   int            done_cnt = 0;
   int            viol_cnt = 0;
   logic          prev_stall = 1'b0;
   logic [7:0]    prev_data = 8'h00;

   logic [7:0]    exp_q[$];
   int            got_ptr = 0;
   int            n_checks = 0;
   int            n_pass = 0;

   num_ascii_serializer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   always #5 clk = ~clk;

   assign tx_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? rnd_bit : 1'b0;

   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      cyc     <= cyc + 1;
   end

   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            got_cyc.push_back(cyc);
         end
         if (done) done_cnt++;
         if (prev_stall && (!tx_valid || tx_data !== prev_data)) viol_cnt++;
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic push_num(input logic [31:0] v, input bit last);
      string s;
      s = $sformatf("%0d", $signed(v));
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(last ? 8'h0A : 8'h20);
   endtask

   task automatic start_job(input int c, output int t);
      @(posedge clk); #1;
      start = 1'b1;
      count = c[AW:0];
      t     = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; count = '0; ready_mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
      n_checks++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b, expected 0", done); else n_pass++;
      n_checks++;
      if (tx_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", tx_valid);
      else n_pass++;
      n_checks++;
      if (tx_data !== 8'h00) $display("FAIL reset_data: got %h, expected 00", tx_data);
      else n_pass++;
      n_checks++;
      if (rd_addr !== '0) $display("FAIL reset_addr: got %h, expected 0", rd_addr);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int t, p0, base, done_at;
      bit ok;
      logic [7:0] e;
      mem[0] = 32'd5; mem[1] = 32'hFFFF_FFF4; mem[2] = 32'd0;
      ready_mode = 0; base = done_cnt; p0 = got_ptr;
      push_num(32'd5, 0); push_num(32'hFFFF_FFF4, 0); push_num(32'd0, 1);
      start_job(3, t);
      @(negedge clk);
      n_checks++;
      if (rd_addr !== '0) $display("FAIL basic_rd_addr: got %h, expected 0", rd_addr);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL basic_busy: got %b, expected 1", busy); else n_pass++;
      wait_done(500, ok);
      done_at = cyc;
      n_checks++;
      if (!ok) $display("FAIL basic_done_seen: got timeout, expected done pulse"); else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b, expected 0", busy);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (done_cnt - base != 1) $display("FAIL basic_done_count: got %0d, expected 1",
                                         done_cnt - base);
      else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_ptr < got_q.size() && got_q[got_ptr] === e) n_pass++;
         else $display("FAIL basic_byte%0d: got %h, expected %h", got_ptr - p0,
                       (got_ptr < got_q.size()) ? got_q[got_ptr] : 8'hxx, e);
         got_ptr++;
      end
      n_checks++;
      if (got_q.size() != got_ptr) $display("FAIL basic_extra_bytes: got %0d, expected %0d",
                                            got_q.size(), got_ptr);
      else n_pass++;
      if (got_cyc.size() >= p0 + 8) begin
         n_checks++;
         if (got_cyc[p0] != t + 35) $display("FAIL basic_latency: got t+%0d, expected t+35",
                                             got_cyc[p0] - t);
         else n_pass++;
         n_checks++;
         if (got_cyc[p0+2] - got_cyc[p0+1] != 35)
            $display("FAIL basic_gap: got %0d, expected 35", got_cyc[p0+2] - got_cyc[p0+1]);
         else n_pass++;
         n_checks++;
         if (done_at != got_cyc[p0+7] + 1)
            $display("FAIL basic_done_time: got %0d, expected %0d", done_at, got_cyc[p0+7] + 1);
         else n_pass++;
      end
   endtask

   task automatic test_extremes();
      int t, p0, base;
      bit ok;
      logic [7:0] e;
      mem[0] = 32'h7FFF_FFFF; mem[1] = 32'h8000_0000;
      ready_mode = 0; base = done_cnt; p0 = got_ptr;
      push_num(32'h7FFF_FFFF, 0); push_num(32'h8000_0000, 1);
      start_job(2, t);
      wait_done(500, ok);
      n_checks++;
      if (!ok) $display("FAIL ext_done_seen: got timeout, expected done pulse"); else n_pass++;
      repeat (3) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_ptr < got_q.size() && got_q[got_ptr] === e) n_pass++;
         else $display("FAIL ext_byte%0d: got %h, expected %h", got_ptr - p0,
                       (got_ptr < got_q.size()) ? got_q[got_ptr] : 8'hxx, e);
         got_ptr++;
      end
      n_checks++;
      if (done_cnt - base != 1) $display("FAIL ext_done_count: got %0d, expected 1",
                                         done_cnt - base);
      else n_pass++;
      if (got_cyc.size() > p0) begin
         n_checks++;
         if (got_cyc[p0] != t + 35) $display("FAIL ext_latency: got t+%0d, expected t+35",
                                             got_cyc[p0] - t);
         else n_pass++;
      end
   endtask

   task automatic test_zero_count();
      int t, p, base;
      base = done_cnt; p = got_q.size();
      start_job(0, t);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1) $display("FAIL zero_done_t1: got %b, expected 1", done); else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL zero_busy_t1: got %b, expected 0", busy); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL zero_done_t2: got %b, expected 0", done); else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (got_q.size() != p) $display("FAIL zero_no_bytes: got %0d, expected %0d",
                                      got_q.size(), p);
      else n_pass++;
      n_checks++;
      if (done_cnt - base != 1) $display("FAIL zero_done_count: got %0d, expected 1",
                                         done_cnt - base);
      else n_pass++;
   endtask

   task automatic test_stall();
      int t, p0, base, v0;
      bit ok;
      logic [7:0] e;
      mem[0] = 32'd1234;
      base = done_cnt; p0 = got_ptr; v0 = viol_cnt;
      push_num(32'd1234, 1);
      ready_mode = 1;
      start_job(1, t);
      wait_done(2000, ok);
      n_checks++;
      if (!ok) $display("FAIL stall_done_seen: got timeout, expected done pulse"); else n_pass++;
      @(posedge clk); #1;
      ready_mode = 0;
      repeat (3) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_ptr < got_q.size() && got_q[got_ptr] === e) n_pass++;
         else $display("FAIL stall_byte%0d: got %h, expected %h", got_ptr - p0,
                       (got_ptr < got_q.size()) ? got_q[got_ptr] : 8'hxx, e);
         got_ptr++;
      end
      n_checks++;
      if (viol_cnt != v0) $display("FAIL stall_stability: got %0d violations, expected 0",
                                   viol_cnt - v0);
      else n_pass++;
      n_checks++;
      if (done_cnt - base != 1) $display("FAIL stall_done_count: got %0d, expected 1",
                                         done_cnt - base);
      else n_pass++;
   endtask

   task automatic test_back_to_back_start();
      int t, p0, base;
      bit ok;
      logic [7:0] e;
      mem[0] = 32'd5; mem[1] = 32'hFFFF_FFF4; mem[2] = 32'd0;
      ready_mode = 0; base = done_cnt; p0 = got_ptr;
      push_num(32'd5, 0); push_num(32'hFFFF_FFF4, 0); push_num(32'd0, 1);
      start_job(3, t);
      repeat (20) @(posedge clk);
      #1; start = 1'b1; count = 12'd1;
      @(posedge clk); #1; start = 1'b0;
      repeat (14) @(posedge clk);
      #1; start = 1'b1; count = 12'd2;
      @(posedge clk); #1; start = 1'b0;
      wait_done(500, ok);
      n_checks++;
      if (!ok) $display("FAIL b2b_done_seen: got timeout, expected done pulse"); else n_pass++;
      repeat (10) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_ptr < got_q.size() && got_q[got_ptr] === e) n_pass++;
         else $display("FAIL b2b_byte%0d: got %h, expected %h", got_ptr - p0,
                       (got_ptr < got_q.size()) ? got_q[got_ptr] : 8'hxx, e);
         got_ptr++;
      end
      n_checks++;
      if (done_cnt - base != 1) $display("FAIL b2b_done_count: got %0d, expected 1",
                                         done_cnt - base);
      else n_pass++;
      n_checks++;
      if (got_q.size() != got_ptr) $display("FAIL b2b_extra_bytes: got %0d, expected %0d",
                                            got_q.size(), got_ptr);
      else n_pass++;
   endtask

   task automatic test_reset_mid_job();
      int t, p0, base;
      bit ok;
      logic [7:0] e;
      mem[0] = 32'd987;
      ready_mode = 0; base = done_cnt; p0 = got_ptr;
      exp_q.push_back(8'h39);
      start_job(1, t);
      repeat (35) @(posedge clk);
      #1; ready_mode = 2;
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h38)
         $display("FAIL rstmid_stalled_digit: got v=%b d=%h, expected v=1 d=38", tx_valid, tx_data);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h38)
         $display("FAIL rstmid_hold: got v=%b d=%h, expected v=1 d=38", tx_valid, tx_data);
      else n_pass++;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b0) $display("FAIL rstmid_valid: got %b, expected 0", tx_valid);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, expected 0", busy); else n_pass++;
      @(posedge clk); #1; rst = 1'b0; ready_mode = 0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (done_cnt != base) $display("FAIL rstmid_no_done: got %0d, expected 0",
                                     done_cnt - base);
      else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_ptr < got_q.size() && got_q[got_ptr] === e) n_pass++;
         else $display("FAIL rstmid_byte%0d: got %h, expected %h", got_ptr - p0,
                       (got_ptr < got_q.size()) ? got_q[got_ptr] : 8'hxx, e);
         got_ptr++;
      end
      n_checks++;
      if (got_q.size() != got_ptr) $display("FAIL rstmid_no_more_bytes: got %0d, expected %0d",
                                            got_q.size(), got_ptr);
      else n_pass++;
      p0 = got_ptr;
      push_num(32'd987, 1);
      start_job(1, t);
      wait_done(500, ok);
      n_checks++;
      if (!ok) $display("FAIL replay_done_seen: got timeout, expected done pulse"); else n_pass++;
      repeat (3) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_ptr < got_q.size() && got_q[got_ptr] === e) n_pass++;
         else $display("FAIL replay_byte%0d: got %h, expected %h", got_ptr - p0,
                       (got_ptr < got_q.size()) ? got_q[got_ptr] : 8'hxx, e);
         got_ptr++;
      end
      n_checks++;
      if (done_cnt - base != 1) $display("FAIL replay_done_count: got %0d, expected 1",
                                         done_cnt - base);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; count = '0;
      test_reset();
      test_basic();
      test_extremes();
      test_zero_count();
      test_stall();
      test_back_to_back_start();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
